pe_rr_arbiter: RTL and testbench
================================

Name: pe_rr_arbiter

Overview:
- Parametrised successor to the 8x3 priority encoder.
- Accepts an N-bit request vector and selects one winner, in either fixed-priority mode (highest index wins) or round-robin mode.
- The winner is presented as a registered index plus one-hot grant, held under a valid/ready handshake until the consumer accepts it.
- Sits between request sources (interrupt lines, channel requests) and a single shared consumer.

Parameters:
- N, 8, number of request inputs; legal range 2..64.
- W, $clog2(N), width of the grant index; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; when 0, no new grant is computed.
- mode  input  1  0 = fixed priority (index N-1 highest, index 0 lowest); 1 = round-robin.
- req  input  N  request vector, level-sensitive, sampled every cycle.
- gnt_ready  input  1  consumer accepts the current grant.
- gnt_valid  output  1  a grant is presented.
- gnt_idx  output  W  binary index of the granted request.
- gnt_onehot  output  N  one-hot form of gnt_idx; all zeros when gnt_valid=0.
- any_req  output  1  registered OR of req, updated every cycle regardless of en.

Behaviour:
- Reset (async on rst_n=0):
  - gnt_valid=0, gnt_idx=0, gnt_onehot=0, any_req=0.
  - Round-robin pointer ptr=N-1.
  - FSM returns to IDLE immediately.
  - Deassertion is synchronous to clk through the flops.
- FSM has two states, IDLE and GRANT.
  - IDLE: on a clock edge with en=1 and req!=0, compute the winner from req and mode, register it into gnt_idx/gnt_onehot, set gnt_valid=1, and go to GRANT. Otherwise stay in IDLE with gnt_valid=0.
  - GRANT: hold gnt_idx, gnt_onehot and gnt_valid stable until an edge where gnt_ready=1.
  - On acceptance with en=1 and req!=0, compute the next winner in the same edge, so gnt_valid stays 1. This allows back-to-back grants at one per cycle.
  - On acceptance with en=0 or req==0, go to IDLE and clear gnt_valid and gnt_onehot. gnt_idx keeps its last value.
- Latency: the grant appears one cycle after the first edge that samples a qualifying req.
- Grants are sticky. Once presented, a grant is held even if its req bit drops, en drops or mode changes, until it is accepted. gnt_ready while gnt_valid=0 is ignored.
- Fixed mode (mode=0):
  - The winner is the highest set index of req.
  - ptr is still updated on every acceptance, so switching to round-robin continues fairly from the last grant.
- Round-robin mode (mode=1):
  - Search downward starting at ptr and wrapping from 0 to N-1. The first set bit wins.
  - On acceptance of index k, ptr becomes k-1, or N-1 when k=0.
  - Because the first search starts at N-1, the first grant after reset matches fixed mode.
- Winner computation always uses the current-cycle req and the pointer value as updated by any acceptance in that same edge.
- mode is sampled only at the edge where a new winner is computed.
- The selection logic is a parametrised loop over N; no hand-unrolled per-N logic. Non-power-of-two N is legal. gnt_idx never exceeds N-1.
- any_req is a 1-cycle registered OR of req and is not gated by en.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF -> gnt_valid=0, gnt_onehot=0, any_req=0. Release reset, then on the first edge with en=1 -> gnt_idx=7, gnt_onehot=8'h80 one cycle later.
- Fixed priority with stall: mode=0, req=8'b0001_0100, gnt_ready=0 for 3 cycles -> gnt_idx=4 held stable for all 3 cycles. Drop req to 0 during the hold -> grant still held. Assert ready -> gnt_valid=0 the next cycle.
- Round-robin fairness: mode=1, req=8'hFF held, gnt_ready=1 continuously -> gnt_idx sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles with gnt_valid constantly 1.
- Round-robin skip and wrap: mode=1, ptr at 1 after accepting index 2, req=8'b1000_0001 -> grant 0, then 7, then 0.
- Enable and mode changes: with a grant pending, drop en and toggle mode -> grant held until accepted, then IDLE. Raise en with req=8'h02 -> gnt_idx=1 one cycle later.
- Async reset mid-operation: assert rst_n=0 between edges while gnt_valid=1 -> outputs clear without waiting for a clock edge. After release, ptr=N-1, so req=8'h81 in mode 1 grants 7 first.

Source files
------------

// File: rtl/pe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pe_rr_arbiter
// Brief    : N-input arbiter with fixed-priority or round-robin selection and
//            a registered, sticky grant held under a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module pe_rr_arbiter #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic         i_mode,
    input  logic [N-1:0] i_req,
    input  logic         i_gnt_ready,
    output logic         o_gnt_valid,
    output logic [W-1:0] o_gnt_idx,
    output logic [N-1:0] o_gnt_onehot,
    output logic         o_any_req
);

    localparam logic [W-1:0] C_TOP = W'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [W-1:0]   r_ptr;
    logic [W-1:0]   r_idx;
    logic [N-1:0]   r_onehot;
    logic           r_any;

    logic           w_accept;
    logic           w_load;
    logic [W-1:0]   w_ptr_eff;
    logic [W-1:0]   w_start;
    logic [W-1:0]   w_win;
    logic           w_found;

    // The pointer seen by this edge's search already reflects an acceptance
    // happening on the same edge, so back-to-back grants stay fair.
    always_comb begin
        w_accept  = (r_state == ST_GRANT) && i_gnt_ready;
        w_ptr_eff = r_ptr;
        if (w_accept) begin
            w_ptr_eff = (r_idx == '0) ? C_TOP : r_idx - 1'b1;
        end
        w_start = i_mode ? w_ptr_eff : C_TOP;
        w_load  = i_en && (|i_req) && ((r_state == ST_IDLE) || w_accept);
    end

    // Downward search from w_start with wrap; fixed mode starts at N-1.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = int'(w_start) - i;
            if (j < 0) begin
                j = j + N;
            end
            if (!w_found && i_req[j]) begin
                w_win   = W'(j);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_load) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    w_state_next = w_load ? ST_GRANT : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= '0;
            r_onehot <= '0;
            r_ptr    <= C_TOP;
        end else begin
            if (w_accept) begin
                r_ptr <= w_ptr_eff;
            end
            if (w_load) begin
                r_idx    <= w_win;
                r_onehot <= N'(1) << w_win;
            end else if (w_accept) begin
                r_onehot <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |i_req;
        end
    end

    assign o_gnt_valid  = (r_state == ST_GRANT);
    assign o_gnt_idx    = r_idx;
    assign o_gnt_onehot = r_onehot;
    assign o_any_req    = r_any;

endmodule
`default_nettype wire

// File: tb/tb_pe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_rr_arbiter
// Brief    : Directed self-checking bench for pe_rr_arbiter (N=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_rr_arbiter;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         r_en;
    logic         r_mode;
    logic [N-1:0] r_req;
    logic         r_ready;
    logic         w_valid;
    logic [W-1:0] w_idx;
    logic [N-1:0] w_onehot;
    logic         w_any;

    int n_err;
    int n_chk;

    pe_rr_arbiter #(.N(N)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_en         (r_en),
        .i_mode       (r_mode),
        .i_req        (r_req),
        .i_gnt_ready  (r_ready),
        .o_gnt_valid  (w_valid),
        .o_gnt_idx    (w_idx),
        .o_gnt_onehot (w_onehot),
        .o_any_req    (w_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Outputs are sampled and inputs driven 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        n_err   = 0;
        n_chk   = 0;
        rst_n   = 1'b0;
        r_en    = 1'b0;
        r_mode  = 1'b0;
        r_req   = 8'hFF;
        r_ready = 1'b0;

        // Reset holds everything clear even with requests present
        repeat (2) tick();
        chk("rst_valid",  64'(w_valid),  64'd0);
        chk("rst_onehot", 64'(w_onehot), 64'h00);
        chk("rst_any",    64'(w_any),    64'd0);

        rst_n = 1'b1;
        r_en  = 1'b1;
        tick();
        chk("first_idx",    64'(w_idx),    64'd7);
        chk("first_onehot", 64'(w_onehot), 64'h80);
        chk("first_valid",  64'(w_valid),  64'd1);
        chk("first_any",    64'(w_any),    64'd1);
        r_ready = 1'b1;
        r_en    = 1'b0;
        tick();
        chk("first_drop", 64'(w_valid), 64'd0);

        // Fixed priority with stall; req drops during the hold
        r_en    = 1'b1;
        r_mode  = 1'b0;
        r_req   = 8'b0001_0100;
        r_ready = 1'b0;
        tick();
        chk("fix_idx0",   64'(w_idx),    64'd4);
        chk("fix_oh0",    64'(w_onehot), 64'h10);
        r_req = 8'h00;
        tick();
        chk("fix_idx1",   64'(w_idx),    64'd4);
        chk("fix_valid1", 64'(w_valid),  64'd1);
        chk("fix_any0",   64'(w_any),    64'd0);
        tick();
        chk("fix_idx2",   64'(w_idx),    64'd4);
        chk("fix_valid2", 64'(w_valid),  64'd1);
        r_ready = 1'b1;
        tick();
        chk("fix_rel_valid", 64'(w_valid),  64'd0);
        chk("fix_rel_oh",    64'(w_onehot), 64'h00);
        chk("fix_rel_idx",   64'(w_idx),    64'd4);

        // Round-robin fairness from a fresh pointer
        do_reset();
        r_mode  = 1'b1;
        r_req   = 8'hFF;
        r_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rr_idx%0d", k), 64'(w_idx), 64'((15 - k) % 8));
            chk($sformatf("rr_val%0d", k), 64'(w_valid), 64'd1);
        end

        // Walk down to index 2, then skip/wrap with req=1000_0001
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_walk%0d", k), 64'(w_idx), 64'(6 - k));
        end
        r_req = 8'b1000_0001;
        tick();
        chk("wrap_a", 64'(w_idx), 64'd0);
        tick();
        chk("wrap_b", 64'(w_idx), 64'd7);
        chk("wrap_b_oh", 64'(w_onehot), 64'h80);
        tick();
        chk("wrap_c", 64'(w_idx), 64'd0);

        // Sticky grant across en drop and mode toggles
        r_ready = 1'b0;
        r_en    = 1'b0;
        r_mode  = 1'b0;
        tick();
        chk("sticky_idx0", 64'(w_idx),   64'd0);
        chk("sticky_val0", 64'(w_valid), 64'd1);
        r_mode = 1'b1;
        tick();
        chk("sticky_oh1",  64'(w_onehot), 64'h01);
        r_ready = 1'b1;
        tick();
        chk("en_off_valid", 64'(w_valid), 64'd0);
        r_ready = 1'b0;
        r_en    = 1'b1;
        r_req   = 8'h02;
        tick();
        chk("en_on_idx", 64'(w_idx),    64'd1);
        chk("en_on_oh",  64'(w_onehot), 64'h02);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(w_valid),  64'd0);
        chk("arst_oh",    64'(w_onehot), 64'h00);
        chk("arst_idx",   64'(w_idx),    64'd0);
        chk("arst_any",   64'(w_any),    64'd0);
        r_req  = 8'h81;
        r_mode = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_idx", 64'(w_idx), 64'd7);
        r_ready = 1'b1;
        tick();
        chk("post_rst_next", 64'(w_idx), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
